disp_scan_ctrl: RTL and testbench

- 4-digit multiplexed seven-segment scan controller for the board display.
- Generates its own per-digit refresh tick from `clk` with a clock-enable counter; no derived clocks.
- Rotates active-low anodes, decodes hex nibbles to active-low segments, and applies optional leading-zero blanking.
- Double-buffers the displayed value. New values are committed only at frame boundaries, so the display never tears mid-frame.

---
 rtl/disp_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
//   Scan controller for a 4-digit multiplexed seven-segment display.
//   A clock-enable counter gives each digit TICK_DIV cycles of on-time. The
//   controller rotates the active-low anodes and decodes hex nibbles to
//   active-low segments. Leading zeros can be blanked. New values go into a
//   pending buffer and are committed to the shadow (displayed) buffer only
//   at a frame boundary, so a frame is never torn.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high
//   en         1 = scanning; 0 = display dark, scan frozen
//   value      16-bit hex value; nibble k drives digit k (digit 0 = an[0])
//   dp         decimal-point request per digit, 1 = on
//   load       one-cycle strobe capturing value/dp into the pending buffer
//   load_done  one-cycle pulse when pending data reaches the shadow buffer
//   an         digit anodes, active-low
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp_n       decimal point, active-low
//   frame_tick one-cycle pulse per completed 4-digit frame
module disp_scan_ctrl #(
    parameter int unsigned TICK_DIV = 20000,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        load,
    output logic        load_done,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_tick
);

    localparam int unsigned     CW      = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shadow_val;
    logic [3:0]    shadow_dp;
    logic [15:0]   pend_val;
    logic [3:0]    pend_dp;
    logic          pend;

    logic          tick;
    logic          boundary;
    logic          commit;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign tick     = en && (cnt == CNT_MAX);
    assign boundary = tick && (idx == 2'd3);
    // While disabled there is no frame to protect, so anything waiting
    // commits at once and pend is never left set.
    assign commit   = (boundary || !en) && (pend || load);

    always_comb begin
        nib   = '0;
        blank = 1'b0;
        case (idx)
            2'd0: begin
                nib   = shadow_val[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                nib   = shadow_val[7:4];
                blank = (shadow_val[15:4] == 12'h000);
            end
            2'd2: begin
                nib   = shadow_val[11:8];
                blank = (shadow_val[15:8] == 8'h00);
            end
            default: begin
                nib   = shadow_val[15:12];
                blank = (shadow_val[15:12] == 4'h0);
            end
        endcase
        blank = blank && LZ_BLANK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend       <= 1'b0;
            an         <= '1;
            seg        <= '1;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            if (tick) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else if (en) begin
                cnt <= cnt + 1'b1;
            end

            frame_tick <= boundary;
            load_done  <= commit;

            // A load in the commit cycle bypasses the pending buffer.
            if (commit) begin
                shadow_val <= load ? value : pend_val;
                shadow_dp  <= load ? dp    : pend_dp;
                pend       <= 1'b0;
            end else if (load) begin
                pend_val <= value;
                pend_dp  <= dp;
                pend     <= 1'b1;
            end

            if (!en || blank) begin
                an   <= '1;
                seg  <= '1;
                dp_n <= 1'b1;
            end else begin
                an   <= ~(4'b0001 << idx);
                seg  <= hex_to_seg(nib);
                dp_n <= ~shadow_dp[idx];
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl
//   Directed bench for disp_scan_ctrl with TICK_DIV=4. A second instance
//   with LZ_BLANK=0 shares all inputs so that the unblanked digits can be
//   compared on the same timeline. Expected values are hand-derived cycle
//   positions: cyc n is sampled 1 time unit after the n-th edge following
//   reset release, and it reflects the digit index held before that edge.
module tb_disp_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;

    logic        load_done, load_done_nz;
    logic [3:0]  an, an_nz;
    logic [6:0]  seg, seg_nz;
    logic        dp_n, dp_n_nz;
    logic        frame_tick, frame_tick_nz;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc    = 0;
    int unsigned ld_cnt;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.TICK_DIV(4), .LZ_BLANK(1'b1)) u_dut (
        .clk(clk), .reset(reset), .en(en), .value(value), .dp(dp),
        .load(load), .load_done(load_done), .an(an), .seg(seg),
        .dp_n(dp_n), .frame_tick(frame_tick)
    );

    disp_scan_ctrl #(.TICK_DIV(4), .LZ_BLANK(1'b0)) u_nolz (
        .clk(clk), .reset(reset), .en(en), .value(value), .dp(dp),
        .load(load), .load_done(load_done_nz), .an(an_nz), .seg(seg_nz),
        .dp_n(dp_n_nz), .frame_tick(frame_tick_nz)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int unsigned n);
        while (cyc < n) step();
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        value = '0;
        dp    = '0;
        load  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_an",   16'(an), 16'hF);
        check("rst_seg",  16'(seg), 16'h7F);
        check("rst_dpn",  16'(dp_n), 16'h1);
        check("rst_ft",   16'(frame_tick), 16'h0);
        check("rst_ld",   16'(load_done), 16'h0);
        reset = 1'b0;
        cyc   = 0;

        // Reset scan, then a load captured at edge 5
        run_to(1);
        check("s_an0",  16'(an), 16'hE);
        check("s_seg0", 16'(seg), 16'h40);
        check("s_dpn0", 16'(dp_n), 16'h1);
        run_to(4);
        value = 16'h12A0; dp = 4'b0100; load = 1'b1;
        run_to(5);
        load = 1'b0; value = '0; dp = '0;
        run_to(6);  check("blank1", 16'(an), 16'hF);
        check("nz_an1", 16'(an_nz), 16'hD);
        run_to(10); check("blank2", 16'(an), 16'hF);
        run_to(14); check("blank3", 16'(an), 16'hF);
        run_to(15); check("ft15", 16'(frame_tick), 16'h0);
        check("ld15", 16'(load_done), 16'h0);
        run_to(16); check("ft16", 16'(frame_tick), 16'h1);
        check("ld16", 16'(load_done), 16'h1);
        check("an16", 16'(an), 16'hF);
        run_to(17); check("ft17", 16'(frame_tick), 16'h0);
        check("ld17", 16'(load_done), 16'h0);
        check("l_an0", 16'(an), 16'hE);  check("l_seg0", 16'(seg), 16'h40);
        run_to(21); check("l_an1", 16'(an), 16'hD);  check("l_seg1", 16'(seg), 16'h08);
        check("l_dpn1", 16'(dp_n), 16'h1);
        run_to(25); check("l_an2", 16'(an), 16'hB);  check("l_seg2", 16'(seg), 16'h24);
        check("l_dpn2", 16'(dp_n), 16'h0);
        run_to(29); check("l_an3", 16'(an), 16'h7);  check("l_seg3", 16'(seg), 16'h79);
        check("l_dpn3", 16'(dp_n), 16'h1);
        run_to(32); check("ft32", 16'(frame_tick), 16'h1);
        check("ld32", 16'(load_done), 16'h0);

        // Load coincident with the boundary at edge 48
        run_to(47);
        value = 16'h3456; dp = 4'b0001; load = 1'b1;
        run_to(48);
        load = 1'b0; value = '0; dp = '0;
        check("c_ld48", 16'(load_done), 16'h1);
        check("c_ft48", 16'(frame_tick), 16'h1);
        run_to(49); check("c_ld49", 16'(load_done), 16'h0);
        check("c_seg0", 16'(seg), 16'h02);  check("c_dpn0", 16'(dp_n), 16'h0);
        run_to(53); check("c_seg1", 16'(seg), 16'h12);
        run_to(64); check("c_ft64", 16'(frame_tick), 16'h1);
        check("c_ld64", 16'(load_done), 16'h0);

        // Back-to-back loads in frame 65..80; only the second one survives
        ld_cnt = 0;
        run_to(65);
        value = 16'h0001; load = 1'b1;
        step(); if (load_done) ld_cnt++;
        load = 1'b0;
        run_to(69);
        value = 16'h00FF; load = 1'b1;
        step(); if (load_done) ld_cnt++;
        load = 1'b0; value = '0;
        while (cyc < 96) begin
            step();
            if (load_done) ld_cnt++;
            if (cyc == 80) check("b_ld80", 16'(load_done), 16'h1);
            if (cyc == 81) begin
                check("b_an0", 16'(an), 16'hE); check("b_seg0", 16'(seg), 16'h0E);
            end
            if (cyc == 85) begin
                check("b_an1", 16'(an), 16'hD); check("b_seg1", 16'(seg), 16'h0E);
            end
            if (cyc == 89) begin
                check("b_an2", 16'(an), 16'hF);
                check("nz_an2", 16'(an_nz), 16'hB); check("nz_seg2", 16'(seg_nz), 16'h40);
            end
            if (cyc == 93) begin
                check("b_an3", 16'(an), 16'hF);
                check("nz_an3", 16'(an_nz), 16'h7); check("nz_seg3", 16'(seg_nz), 16'h40);
            end
        end
        check("b_ldcount", 16'(ld_cnt), 16'd1);

        // Enable gating: drop en at idx=2, load while dark, resume at idx=2
        run_to(105);
        en = 1'b0;
        while (cyc < 115) begin
            if (cyc == 107) begin value = 16'hBEEF; dp = 4'b0000; load = 1'b1; end
            step();
            load = 1'b0;
            check("g_an", 16'(an), 16'hF);
            check("g_seg", 16'(seg), 16'h7F);
            if (cyc == 108) check("g_ld108", 16'(load_done), 16'h1);
            if (cyc == 109) check("g_ld109", 16'(load_done), 16'h0);
        end
        value = '0;
        en = 1'b1;
        run_to(116); check("r_an2", 16'(an), 16'hB); check("r_seg2", 16'(seg), 16'h06);
        run_to(119); check("r_an3", 16'(an), 16'h7); check("r_seg3", 16'(seg), 16'h03);
        run_to(122); check("r_ft122", 16'(frame_tick), 16'h1);

        // Reset while pend=1 and idx=3
        run_to(129);
        value = 16'h9999; dp = 4'b1111; load = 1'b1;
        run_to(130);
        load = 1'b0; value = '0; dp = '0;
        run_to(135);
        reset = 1'b1;
        run_to(137);
        check("m_an",  16'(an), 16'hF);
        check("m_seg", 16'(seg), 16'h7F);
        check("m_dpn", 16'(dp_n), 16'h1);
        check("m_ft",  16'(frame_tick), 16'h0);
        check("m_ld",  16'(load_done), 16'h0);
        reset = 1'b0;
        ld_cnt = 0;
        while (cyc < 160) begin
            step();
            if (load_done) ld_cnt++;
            if (cyc == 138) begin
                check("m_an0", 16'(an), 16'hE); check("m_seg0", 16'(seg), 16'h40);
                check("m_dpn0", 16'(dp_n), 16'h1);
            end
            if (cyc == 142) check("m_an1", 16'(an), 16'hF);
            if (cyc == 152) check("m_ft152", 16'(frame_tick), 16'h0);
            if (cyc == 153) check("m_ft153", 16'(frame_tick), 16'h1);
            if (cyc == 154) begin
                check("m_an0b", 16'(an), 16'hE); check("m_seg0b", 16'(seg), 16'h40);
            end
        end
        check("m_ldcount", 16'(ld_cnt), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
